// File: rtl/term_pkg.sv
// Shared types and constants for the term loader: FSM state, term count, term vector.
// N/F default to the project-wide `N/`F word format unless predefined by the build.
`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

package term_pkg;

    localparam int unsigned TERM_N    = `N;
    localparam int unsigned TERM_F    = `F;
    localparam int unsigned NUM_TERMS = 16;

    typedef enum logic {
        StFill,
        StHold
    } state_t;

    // Index 0 is the first accepted pair.
    typedef logic [0:NUM_TERMS-1][TERM_N-1:0] term_vec_t;

endpackage

// File: rtl/sm_mult.sv
// Combinational signed-magnitude fixed-point multiplier with truncation toward zero.
// Define TERM_LOADER_SAT_EN to saturate overflowing magnitudes instead of wrapping.
module sm_mult #(
    parameter int N = 16,
    parameter int F = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] w,
    output logic [N-1:0] p,
    output logic         ovf
);

    localparam int M = N - 1;

    logic [2*M-1:0] full;
    logic [2*M-1:0] shifted;
    logic [M-1:0]   mag;
    logic           sign;

    always_comb begin
        full    = x[M-1:0] * w[M-1:0];
        shifted = full >> F;
        ovf     = |shifted[2*M-1:M];
`ifdef TERM_LOADER_SAT_EN
        mag     = ovf ? {M{1'b1}} : shifted[M-1:0];
`else
        mag     = shifted[M-1:0];
`endif
        // A zero magnitude always reads as positive zero.
        sign    = (x[N-1] ^ w[N-1]) & (|mag);
        p       = {sign, mag};
    end

endmodule

// File: rtl/term_loader.sv
// Collects 16 signed-magnitude products and hands them to the summation stage as one vector.
// Build option TERM_LOADER_SAT_EN (in sm_mult) selects saturation on product overflow.
module term_loader
    import term_pkg::*;
#(
    parameter int N = `N,
    parameter int F = `F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          x,
    input  logic [N-1:0]          w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:15][N-1:0]    terms,
    output logic [4:0]            fill_count,
    output logic                  ovf
);

    state_t       state;
    logic [3:0]   idx;
    logic [N-1:0] prod;
    logic         prod_ovf;

    sm_mult #(
        .N (N),
        .F (F)
    ) u_mult (
        .x   (x),
        .w   (w),
        .p   (prod),
        .ovf (prod_ovf)
    );

    assign in_ready  = (state == StFill) && rst_n;
    assign out_valid = (state == StHold);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StFill;
            idx        <= '0;
            fill_count <= '0;
            ovf        <= 1'b0;
            terms      <= '0;
        end else if (flush) begin
            state      <= StFill;
            idx        <= '0;
            fill_count <= '0;
            ovf        <= 1'b0;
            terms      <= '0;
        end else begin
            case (state)
                StFill: begin
                    if (in_valid) begin
                        terms[idx] <= prod;
                        ovf        <= ovf | prod_ovf;
                        idx        <= idx + 4'd1;
                        fill_count <= fill_count + 5'd1;
                        if (idx == 4'(NUM_TERMS - 1)) begin
                            state <= StHold;
                        end
                    end
                end
                StHold: begin
                    // Terms stay visible after handoff; only count and flag clear.
                    if (out_ready) begin
                        state      <= StFill;
                        fill_count <= '0;
                        ovf        <= 1'b0;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_term_loader.sv
// Directed self-checking bench for term_loader (N=16, F=8).
module tb_term_loader;
    import term_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      x;
    logic [15:0]      w;
    logic             out_valid;
    logic             out_ready;
    logic [0:15][15:0] terms;
    logic [4:0]       fill_count;
    logic             ovf;

    int n_cmp = 0;
    int n_bad = 0;

    term_vec_t exp_terms;
    term_vec_t snap;

    term_loader #(
        .N (16),
        .F (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .w          (w),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .terms      (terms),
        .fill_count (fill_count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; returns at the following negedge after one transfer edge.
    task automatic push(input logic [15:0] xv, input logic [15:0] wv);
        x        = xv;
        w        = wv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        w         = '0;

        // Reset state
        step();
        step();
        check_eq("rst_in_ready", 256'(in_ready), 256'(0));
        check_eq("rst_out_valid", 256'(out_valid), 256'(0));
        check_eq("rst_fill", 256'(fill_count), 256'(0));
        check_eq("rst_ovf", 256'(ovf), 256'(0));
        check_eq("rst_terms", terms, 256'(0));
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", 256'(in_ready), 256'(1));
        @(negedge clk);

        // 16 x (1.5 * -2.0) = -3.0
        for (int i = 0; i < 15; i++) push(16'h0180, 16'h8200);
        check_eq("fill15_count", 256'(fill_count), 256'(15));
        check_eq("fill15_out_valid", 256'(out_valid), 256'(0));
        push(16'h0180, 16'h8200);
        check_eq("fill16_out_valid", 256'(out_valid), 256'(1));
        check_eq("fill16_count", 256'(fill_count), 256'(16));
        check_eq("fill16_ovf", 256'(ovf), 256'(0));
        for (int i = 0; i < 16; i++) exp_terms[i] = 16'h8300;
        check_eq("fill16_terms", terms, exp_terms);

        // HOLD with back-pressure and in_valid asserted
        in_valid = 1'b1;
        x        = 16'h0100;
        w        = 16'h0100;
        for (int i = 0; i < 10; i++) step();
        check_eq("hold_in_ready", 256'(in_ready), 256'(0));
        check_eq("hold_count", 256'(fill_count), 256'(16));
        check_eq("hold_terms", terms, exp_terms);
        check_eq("hold_out_valid", 256'(out_valid), 256'(1));
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("handoff_out_valid", 256'(out_valid), 256'(0));
        check_eq("handoff_count", 256'(fill_count), 256'(0));
        check_eq("handoff_in_ready", 256'(in_ready), 256'(1));
        check_eq("handoff_no_accept", terms, exp_terms);

        // Overflow, negative zero, underflow, plain negative
        push(16'h7FFF, 16'h7FFF);
`ifdef TERM_LOADER_SAT_EN
        check_eq("ovf_term", 256'(terms[0]), 256'(16'h7FFF));
`else
        check_eq("ovf_term", 256'(terms[0]), 256'(16'h7F00));
`endif
        check_eq("ovf_flag", 256'(ovf), 256'(1));
        push(16'h8000, 16'h0100);
        check_eq("negzero_term", 256'(terms[1]), 256'(16'h0000));
        push(16'h8001, 16'h0001);
        check_eq("underflow_term", 256'(terms[2]), 256'(16'h0000));
        push(16'h8100, 16'h0080);
        check_eq("neg_half_term", 256'(terms[3]), 256'(16'h8080));
        check_eq("sticky_ovf", 256'(ovf), 256'(1));
        check_eq("count4", 256'(fill_count), 256'(4));

        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush1_ovf", 256'(ovf), 256'(0));
        check_eq("flush1_terms", terms, 256'(0));

        // Seven pairs, then flush racing a valid input
        for (int i = 0; i < 7; i++) push(16'(16'h0100 * (i + 1)), 16'h0100);
        check_eq("pre_flush_count", 256'(fill_count), 256'(7));
        check_eq("pre_flush_t6", 256'(terms[6]), 256'(16'h0700));
        x        = 16'h0500;
        w        = 16'h0100;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush2_count", 256'(fill_count), 256'(0));
        check_eq("flush2_terms", terms, 256'(0));
        check_eq("flush2_out_valid", 256'(out_valid), 256'(0));

        // Refill from index 0 with mixed signs, weight +-1.0
        for (int i = 0; i < 16; i++) begin
            logic [15:0] xv;
            logic [15:0] wv;
            xv = 16'(i * 16'h0100 + 16'h0010);
            wv = (i % 2 == 1) ? 16'h8100 : 16'h0100;
            exp_terms[i] = {wv[15], xv[14:0]};
            push(xv, wv);
        end
        check_eq("refill_terms", terms, exp_terms);
        check_eq("refill_out_valid", 256'(out_valid), 256'(1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-fill at fill_count = 9
        push(16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 8; i++) push(16'h0200, 16'h0100);
        check_eq("mid_count", 256'(fill_count), 256'(9));
        check_eq("mid_ovf", 256'(ovf), 256'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 256'(in_ready), 256'(0));
        @(negedge clk);
        check_eq("mid_rst_count", 256'(fill_count), 256'(0));
        check_eq("mid_rst_ovf", 256'(ovf), 256'(0));
        check_eq("mid_rst_terms", terms, 256'(0));
        check_eq("mid_rst_out_valid", 256'(out_valid), 256'(0));
        rst_n = 1'b1;
        #1;
        check_eq("mid_rel_in_ready", 256'(in_ready), 256'(1));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/term_loader.md
TERM_LOADER -- requirements
Module: term_loader

Interface
REQ-001 SHALL have parameter N, default `N` from config.svh (16), total word width in signed-magnitude format (bit N-1 = sign).
REQ-002 SHALL have parameter F, default `F` from config.svh (8), number of fraction bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of the vector being filled.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1  input handshake; a pair transfers when both are high at a clock edge.
REQ-007 SHALL have ports x, w  input  N each  activation and weight, signed magnitude, F fraction bits.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1  output handshake to the 16-input summation stage.
REQ-009 SHALL have port terms  output  [0:15][N]  product vector, index 0 = first accepted pair.
REQ-010 SHALL have port fill_count  output  5  number of terms held, 0..16.
REQ-011 SHALL have port ovf  output  1  high if any product in the current vector overflowed.

Function
REQ-012 SHALL implement FSM states FILL and HOLD; in_ready = (state==FILL) && rst_n; out_valid = (state==HOLD).
REQ-013 SHALL, on each input transfer, write product(x,w) to terms[idx] and increment the 4-bit idx and fill_count.
REQ-014 SHALL, on the 16th transfer, wrap idx to 0, set fill_count to 16, and enter HOLD; out_valid rises the next cycle (latency: 1 cycle after last accept).
REQ-015 SHALL hold terms, ovf and fill_count stable throughout HOLD; in_ready is low in HOLD, so in_valid is ignored.
REQ-016 SHALL, on out_valid && out_ready, return to FILL with fill_count=0 and ovf=0; no input is accepted in that same cycle.
REQ-017 SHALL compute product sign = x[N-1]^w[N-1] and magnitude = (x[N-2:0]*w[N-2:0]) >> F, truncating toward zero.
REQ-018 SHALL force sign to 0 when the result magnitude is 0 (no negative zero).
REQ-019 SHALL flag overflow when the shifted magnitude exceeds N-1 bits, and set ovf (sticky until handoff or flush).
REQ-020 SHALL give flush priority over both handshakes: next state FILL, idx=0, fill_count=0, ovf=0, all terms zeroed.
REQ-021 SHALL tie unfilled terms entries to their reset value (zero) after a flush or reset.

Reset
REQ-022 SHALL, with rst_n low at a clock edge, set state=FILL, idx=0, fill_count=0, ovf=0, terms all 0, out_valid=0.
REQ-023 SHALL hold in_ready low while rst_n is low; reset mid-fill discards partial terms.

Configuration
REQ-024 SHALL, with TERM_LOADER_SAT_EN defined, saturate overflowing magnitudes to all-ones (N-1 bits) and keep the computed sign.
REQ-025 SHALL, without TERM_LOADER_SAT_EN, keep the low N-1 bits of the shifted magnitude; ovf is still reported.

Structure
REQ-026 SHALL place the FSM state enum, the term-count constant 16, and the term vector typedef in the shared package (term_pkg), with N/F taken from config.svh.
REQ-027 SHALL instantiate one sub-module, sm_mult, a combinational signed-magnitude fixed-point multiplier carrying the sign, shift, saturation and zero-sign rules.

Verification (N=16, F=8)
REQ-028 Stream 16 pairs x=0x0180 (1.5), w=0x8200 (-2.0) -> all terms 0x8300 (-3.0), out_valid rises 1 cycle after the 16th accept, fill_count=16, ovf=0.
REQ-029 Apply x=0x7FFF, w=0x7FFF -> term 0x7FFF with TERM_LOADER_SAT_EN, 0x7F00 without; ovf=1 in both builds.
REQ-030 Apply x=0x8000 (-0), w=0x0100 -> term 0x0000; apply x=0x8001, w=0x0001 (magnitude underflows to 0) -> term 0x0000.
REQ-031 Hold out_ready=0 for 10 cycles in HOLD with in_valid=1 -> no accepts, terms unchanged; then out_ready=1 -> FILL next cycle, fill_count=0.
REQ-032 Accept 7 pairs, assert flush together with in_valid=1 -> no write, fill_count=0, terms all 0; the next 16 pairs fill from index 0.
REQ-033 Drop rst_n for 1 cycle at fill_count=9 -> all outputs return to reset values; in_ready is low during reset and high on the next cycle.
